fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of `decode`. It owns the PC and issues instruction requests over a valid/ready request channel with a single outstanding response. Returned instructions are buffered in a small FIFO and presented as `fetch_data_t` with a valid/enable handshake toward `decode`. Redirects from the branch/jump logic flush the stream and restart fetch at the new target.

---
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fetch_unit                                                        |
// | Brief  : MIPS instruction-fetch stage. Owns the PC, issues single-         |
// |          outstanding instruction requests, buffers returned words in a     |
// |          small FIFO and presents the head to decode. Redirects flush the   |
// |          stream and restart fetch at the new target.                       |
// | Ports  : clk, reset (async, active-low)                                    |
// |          ireq_valid/ireq_addr/ireq_ready    - request channel             |
// |          iresp_valid/iresp_data             - in-order response           |
// |          redirect_valid/redirect_pc         - branch/jump redirect        |
// |          fetch_valid/fetch_data_reg/decode_enable - output to decode      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

package fetch_unit_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        jump;
  } fetch_data_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output fetch_data_t fetch_data_reg,
  input  logic        decode_enable
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(QUEUE_DEPTH - 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         req_pc_q, req_pc_d;
  logic                new_stream_q, new_stream_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  fetch_data_t         mem_q [QUEUE_DEPTH];

  logic                req_fire;
  logic                push;
  logic                pop;

  assign ireq_addr   = pc_q;
  assign fetch_valid = (count_q != '0);
  // Head is forced to zero when empty so stale entries never leak out.
  assign fetch_data_reg = fetch_valid ? mem_q[rd_ptr_q] : '0;

  // A redirect flushes the FIFO, so it also cancels a coincident pop.
  assign pop = fetch_valid & decode_enable & ~redirect_valid;

  // -------------------------------------------------------------------------
  // Control FSM and PC next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    new_stream_d = new_stream_q;
    ireq_valid   = 1'b0;
    req_fire     = 1'b0;
    push         = 1'b0;

    case (state_q)
      S_REQ: begin
        // Gated by reset so nothing is requested while the block is held.
        ireq_valid = reset & (count_q < DEPTH_C) & ~redirect_valid;
        req_fire   = ireq_valid & ireq_ready;
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iresp_valid) begin
          push         = 1'b1;
          new_stream_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (iresp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      new_stream_d = 1'b1;
      push         = 1'b0;
      // An outstanding request must still have its response swallowed.
      if (state_q == S_REQ || iresp_valid) begin
        state_d = S_REQ;
      end else begin
        state_d = S_DROP;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR_C) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR_C) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      new_stream_q <= 1'b1;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      new_stream_q <= new_stream_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{pc: req_pc_q, instruction: iresp_data, jump: new_stream_q};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fetch_unit                                                     |
// | Brief  : Directed self-checking bench for fetch_unit (QUEUE_DEPTH = 2).    |
// |          Memory responses are hand-driven; instruction words are the       |
// |          bitwise inverse of the fetch address.                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  fetch_data_t fetch_data_reg;
  logic        decode_enable;

  int errors;
  int checks;

  fetch_unit #(
    .RESET_PC    (32'hbfc0_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .ireq_ready     (ireq_ready),
    .iresp_valid    (iresp_valid),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_data_reg (fetch_data_reg),
    .decode_enable  (decode_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic xv, input logic [31:0] xpc, input logic de);
    ireq_ready     = rdy;
    iresp_valid    = rv;
    iresp_data     = rd;
    redirect_valid = xv;
    redirect_pc    = xpc;
    decode_enable  = de;
    #1;
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    check_eq({tag, ".ireq_valid"}, 65'(ireq_valid), 65'(v));
    check_eq({tag, ".ireq_addr"},  65'(ireq_addr),  65'(a));
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [64:0] d);
    check_eq({tag, ".fetch_valid"}, 65'(fetch_valid), 65'(v));
    if (v) check_eq({tag, ".fetch_data"}, fetch_data_reg, d);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    step();

    // Reset state
    chk_req("rst", 1'b0, 32'hbfc0_0000);
    check_eq("rst.fetch_valid", 65'(fetch_valid), 65'd0);
    check_eq("rst.fetch_data",  fetch_data_reg,   65'd0);

    // Sequential fetch, 1-cycle latency, decode always enabled
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_req("c0", 1'b1, 32'hbfc0_0000);
    chk_head("c0", 1'b0, 65'd0);
    step();
    drive(1'b1, 1'b1, 32'h403f_ffff, 1'b0, 32'h0, 1'b1);
    chk_req("c1", 1'b0, 32'hbfc0_0004);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_head("c2", 1'b1, {32'hbfc0_0000, 32'h403f_ffff, 1'b1});
    chk_req("c2", 1'b1, 32'hbfc0_0004);
    step();
    drive(1'b1, 1'b1, 32'h403f_fffb, 1'b0, 32'h0, 1'b1);
    chk_head("c3", 1'b0, 65'd0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_head("c4", 1'b1, {32'hbfc0_0004, 32'h403f_fffb, 1'b0});
    chk_req("c4", 1'b1, 32'hbfc0_0008);
    step();
    drive(1'b1, 1'b1, 32'h403f_fff7, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_head("c6", 1'b1, {32'hbfc0_0008, 32'h403f_fff7, 1'b0});
    chk_req("c6", 1'b1, 32'hbfc0_000c);
    step();

    // Reset asserted while a request is outstanding
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_req("mrst", 1'b0, 32'hbfc0_0000);
    check_eq("mrst.fetch_valid", 65'(fetch_valid), 65'd0);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'hdead_beef, 1'b0, 32'h0, 1'b0);
    chk_req("c8", 1'b1, 32'hbfc0_0000);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_head("c9", 1'b0, 65'd0);
    chk_req("c9", 1'b1, 32'hbfc0_0000);
    step();

    // decode stalled: exactly two entries buffered
    drive(1'b1, 1'b1, 32'h403f_ffff, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_req("d2", 1'b1, 32'hbfc0_0004);
    chk_head("d2", 1'b1, {32'hbfc0_0000, 32'h403f_ffff, 1'b1});
    step();
    drive(1'b1, 1'b1, 32'h403f_fffb, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_req("full", 1'b0, 32'hbfc0_0008);
      chk_head("full", 1'b1, {32'hbfc0_0000, 32'h403f_ffff, 1'b1});
      step();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_req("d6", 1'b0, 32'hbfc0_0008);
    step();

    // ireq_ready low for 4 cycles: request held stable
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_req("stall", 1'b1, 32'hbfc0_0008);
      chk_head("stall", 1'b1, {32'hbfc0_0004, 32'h403f_fffb, 1'b0});
      step();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();

    // Redirect while waiting; stale response arrives 3 cycles later
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0);
    chk_req("d12", 1'b0, 32'hbfc0_000c);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_req("d13", 1'b0, 32'h8000_0100);
    chk_head("d13", 1'b0, 65'd0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h403f_fff7, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_req("d16", 1'b1, 32'h8000_0100);
    chk_head("d16", 1'b0, 65'd0);
    step();
    drive(1'b1, 1'b1, 32'h7fff_feff, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_head("d18", 1'b1, {32'h8000_0100, 32'h7fff_feff, 1'b1});
    chk_req("d18", 1'b1, 32'h8000_0104);
    step();
    drive(1'b1, 1'b1, 32'h7fff_fefb, 1'b0, 32'h0, 1'b1);
    chk_head("d19", 1'b0, 65'd0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_head("d20", 1'b1, {32'h8000_0104, 32'h7fff_fefb, 1'b0});
    chk_req("d20", 1'b1, 32'h8000_0108);
    step();

    // Redirect coincident with response and pop, target at the top of memory
    drive(1'b1, 1'b1, 32'h7fff_fef7, 1'b1, 32'hffff_fffc, 1'b1);
    check_eq("d21.ireq_valid", 65'(ireq_valid), 65'd0);
    check_eq("d21.fetch_valid", 65'(fetch_valid), 65'd1);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_head("d22", 1'b0, 65'd0);
    chk_req("d22", 1'b1, 32'hffff_fffc);
    step();
    drive(1'b1, 1'b1, 32'h0000_0003, 1'b0, 32'h0, 1'b0);
    chk_req("wrap", 1'b0, 32'h0000_0000);
    step();

    // Redirect while in REQ gates the request
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0);
    chk_head("d24", 1'b1, {32'hffff_fffc, 32'h0000_0003, 1'b1});
    check_eq("d24.ireq_valid", 65'(ireq_valid), 65'd0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_req("d25", 1'b1, 32'h0000_1000);
    chk_head("d25", 1'b0, 65'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
